// File: rtl/issue_scoreboard.sv
// Issue stage: one-entry holding register in front of execute, gated by a
// register-write scoreboard that blocks RAW/WAW hazards until writeback.
package UOP;
  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_ADDI = 4'd6,
    OP_LD   = 4'd7,
    OP_ST   = 4'd8,
    OP_BR   = 4'd9
  } op_t;

  typedef enum logic [1:0] {
    EX_NONE    = 2'd0,
    EX_DECODE  = 2'd1,
    EX_ILLEGAL = 2'd2
  } ex_t;

  typedef struct packed {
    op_t         op;
    ex_t         ex;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        immValid;
    logic [31:0] imm;
  } dec_t;
endpackage

module issue_scoreboard #(
  parameter int NUM_REGS = 32,
  localparam int RW = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                inValid,
  output logic                inReady,
  input  UOP::dec_t           inDec,
  output logic                outValid,
  input  logic                outReady,
  output UOP::dec_t           outDec,
  input  logic                wbValid,
  input  logic [RW-1:0]       wbRd,
  output logic [NUM_REGS-1:0] busy
);
  logic      holdValid;
  UOP::dec_t hold;
  logic      tracked, raw1, raw2, waw, hazard, fire, accept;

  assign tracked = (hold.rd != '0) && (hold.op != UOP::OP_NOP) && (hold.ex == UOP::EX_NONE);
  assign raw1    = (hold.rs1 != '0) && busy[hold.rs1];
  assign raw2    = !hold.immValid && (hold.rs2 != '0) && busy[hold.rs2];
  assign waw     = tracked && busy[hold.rd];

  // Faulting ops wait for every older write to drain so the trap sees precise state.
  assign hazard   = (hold.ex != UOP::EX_NONE) ? (|busy) : (raw1 || raw2 || waw);
  assign outValid = holdValid && !flush && !hazard;
  assign fire     = outValid && outReady;
  assign inReady  = !holdValid || fire;
  assign accept   = inValid && inReady && !flush;
  assign outDec   = hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      holdValid <= 1'b0;
      hold      <= '0;
    end else if (flush) begin
      holdValid <= 1'b0;
    end else if (accept) begin
      holdValid <= 1'b1;
      hold      <= inDec;
    end else if (fire) begin
      holdValid <= 1'b0;
    end
  end

  for (genvar n = 0; n < NUM_REGS; n++) begin : g_reg
    if (n == 0) begin : g_zero
      assign busy[n] = 1'b0;
    end else begin : g_bit
      logic b, set_n, clr_n;
      assign set_n = fire && tracked && (int'(hold.rd) == n);
      assign clr_n = wbValid && (int'(wbRd) == n);
      // Set beats clear: the issuing op is newer than the one writing back.
      always_ff @(posedge clk) begin
        if (rst)        b <= 1'b0;
        else if (set_n) b <= 1'b1;
        else if (clr_n) b <= 1'b0;
      end
      assign busy[n] = b;
    end
  end
endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed hazard scenarios plus random traffic against a queue/array reference model.
module tb_issue_scoreboard;
  import UOP::*;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst, flush, inValid, inReady, outValid, outReady, wbValid;
  dec_t          inDec, outDec;
  logic [4:0]    wbRd;
  logic [NR-1:0] busy;

  always #5 clk = ~clk;

  issue_scoreboard #(.NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .inValid(inValid), .inReady(inReady), .inDec(inDec),
    .outValid(outValid), .outReady(outReady), .outDec(outDec),
    .wbValid(wbValid), .wbRd(wbRd), .busy(busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: a held op plus the set of registers with a write outstanding.
  bit   m_valid;
  dec_t m_hold;
  bit   m_pend[NR];
  int   inflight[$];

  function automatic bit m_writes(dec_t d);
    return d.rd != 0 && d.op != OP_NOP && d.ex == EX_NONE;
  endfunction

  function automatic bit m_any_pend();
    foreach (m_pend[i]) if (m_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_issuable(dec_t d);
    int reads[$];
    if (d.ex != EX_NONE) return !m_any_pend();
    reads.push_back(int'(d.rs1));
    if (!d.immValid) reads.push_back(int'(d.rs2));
    foreach (reads[i]) if (reads[i] != 0 && m_pend[reads[i]]) return 1'b0;
    if (m_writes(d) && m_pend[d.rd]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void m_reset();
    m_valid = 1'b0;
    m_hold  = '0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    inflight.delete();
  endfunction

  function automatic dec_t mk(op_t op, int rd, int rs1, int rs2, bit imv, ex_t ex);
    dec_t d;
    d          = '0;
    d.op       = op;
    d.ex       = ex;
    d.rd       = 5'(rd);
    d.rs1      = 5'(rs1);
    d.rs2      = 5'(rs2);
    d.immValid = imv;
    d.imm      = 32'h10;
    return d;
  endfunction

  task automatic step(bit r, bit fl, bit iv, dec_t d, bit ordy, bit wv, logic [4:0] wr);
    bit e_ov, e_ir, e_fire, e_acc;
    logic [NR-1:0] pv;
    @(negedge clk);
    rst = r; flush = fl; inValid = iv; inDec = d; outReady = ordy; wbValid = wv; wbRd = wr;
    e_ov   = m_valid && !fl && m_issuable(m_hold);
    e_fire = e_ov && ordy;
    e_ir   = !m_valid || e_fire;
    e_acc  = iv && e_ir && !fl;
    for (int i = 0; i < NR; i++) pv[i] = m_pend[i];
    #1;
    chk("outValid", outValid, e_ov);
    chk("inReady",  inReady,  e_ir);
    chk("outDec",   outDec,   m_hold);
    chk("busy",     busy,     pv);
    @(posedge clk);
    if (r) m_reset();
    else begin
      if (wv && wr != 0) m_pend[wr] = 1'b0;
      if (e_fire && m_writes(m_hold)) begin
        m_pend[m_hold.rd] = 1'b1;
        inflight.push_back(int'(m_hold.rd));
      end
      if (fl)          m_valid = 1'b0;
      else if (e_acc)  begin m_hold = d; m_valid = 1'b1; end
      else if (e_fire) m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, '0, 1, 0, 5'd0);
  endtask

  task automatic wb(int r);
    step(0, 0, 0, '0, 1, 1, 5'(r));
  endtask

  task automatic put(dec_t d);
    step(0, 0, 1, d, 1, 0, 5'd0);
  endtask

  initial begin
    dec_t rd_d;
    bit   r, fl, iv, ordy, wv;
    logic [4:0] wr;
    int   idx;

    rst = 1'b1; flush = 0; inValid = 0; inDec = '0; outReady = 1; wbValid = 0; wbRd = '0;
    repeat (2) @(posedge clk);
    m_reset();
    step(1, 0, 0, '0, 1, 0, 5'd0);
    chk("rst_outValid", outValid, 1'b0);
    chk("rst_inReady",  inReady,  1'b1);
    chk("rst_busy",     busy,     '0);

    // Basic issue and writeback
    put(mk(OP_ADD, 5, 1, 2, 0, EX_NONE));
    idle();
    chk("t1_busy5_set", busy[5], 1'b1);
    wb(5);
    chk("t1_busy5_clr", busy[5], 1'b0);

    // RAW stall until the cycle after writeback
    put(mk(OP_ADD, 3, 1, 2, 0, EX_NONE));
    idle();
    put(mk(OP_ADD, 4, 3, 0, 0, EX_NONE));
    idle(); idle();
    chk("t2_stalled", busy[4], 1'b0);
    wb(3);
    idle();
    chk("t2_busy4", busy[4], 1'b1);
    wb(4);

    // Immediate op ignores rs2 field even when that register is busy
    put(mk(OP_ADD, 3, 1, 2, 0, EX_NONE));
    idle();
    put(mk(OP_ADDI, 6, 0, 3, 1, EX_NONE));
    idle();
    chk("t3_busy6", busy[6], 1'b1);
    chk("t3_busy3", busy[3], 1'b1);
    wb(3); wb(6);

    // WAW stall, then set wins over a same-cycle clear
    put(mk(OP_ADD, 7, 1, 2, 0, EX_NONE));
    idle();
    put(mk(OP_SUB, 7, 1, 2, 0, EX_NONE));
    idle();
    wb(7);
    wb(7);
    chk("t4_set_wins", busy[7], 1'b1);
    wb(7);

    // Exception op waits for all writes to drain and sets nothing
    put(mk(OP_ADD, 9, 1, 2, 0, EX_NONE));
    idle();
    put(mk(OP_ADD, 10, 9, 0, 0, EX_DECODE));
    idle();
    wb(9);
    idle();
    chk("t5_busy_zero", busy, '0);

    // Flush drops the held op and the same-cycle input, keeps busy
    put(mk(OP_ADD, 11, 1, 2, 0, EX_NONE));
    idle();
    put(mk(OP_ADD, 12, 11, 0, 0, EX_NONE));
    step(0, 1, 1, mk(OP_ADD, 13, 1, 2, 0, EX_NONE), 1, 0, 5'd0);
    idle();
    chk("t6_busy11", busy[11], 1'b1);
    chk("t6_busy13", busy[13], 1'b0);
    wb(11);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      r    = ($urandom % 250) == 0;
      fl   = ($urandom % 20) == 0;
      iv   = ($urandom % 4) != 0;
      ordy = ($urandom % 4) != 0;
      rd_d = mk(op_t'($urandom_range(0, 9)), $urandom % 8, $urandom % 8, $urandom % 8,
                1'($urandom % 2), (($urandom % 8) == 0) ? EX_DECODE : EX_NONE);
      rd_d.imm = $urandom;
      wv = 1'b0;
      wr = 5'($urandom % 8);
      if (inflight.size() > 0 && ($urandom % 3) == 0) begin
        idx = int'($urandom % inflight.size());
        wr  = 5'(inflight[idx]);
        inflight.delete(idx);
        wv  = 1'b1;
      end else if (($urandom % 12) == 0) begin
        wv = 1'b1;
      end
      step(r, fl, iv, rd_d, ordy, wv, wr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
